// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetch buffer feeding decode over valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_count;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [63:0]   r_buf [DEPTH];
  logic          w_pop;
  logic          w_push;
  assign w_pop  = if_valid & if_ready & ~redirect_valid;
  // a pop in the same cycle frees the slot the push needs when full
  assign w_push = fetch_en & ~redirect_valid & ((r_count < FULL) | w_pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
      r_count       <= '0;
      r_rd          <= '0;
      r_wr          <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_target & ~32'h3;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr]   <= {r_pc, imem_data};
        r_wr          <= r_wr + AW'(1);
        r_pc          <= r_pc + 32'd4;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  assign imem_addr   = r_pc;
  assign fetch_count = r_fetch_count;
  assign if_valid    = r_count != '0;
  assign if_pc       = if_valid ? r_buf[r_rd][63:32] : '0;
  assign if_instr    = if_valid ? r_buf[r_rd][31:0] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks against a queue-based fetch model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic        clk = 0;
  logic        reset = 1;
  logic        fetch_en = 0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 0;
  logic [31:0] redirect_target = 0;
  logic        if_valid;
  logic        if_ready = 0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] q[$];
  logic [31:0] m_pc = 0;
  logic [31:0] m_fc = 0;
  logic [128:0] obs;

  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'd3 * ((a >> 2) + 32'd1);
  endfunction

  assign imem_data = mem(imem_addr);
  assign obs = {if_valid, if_pc, if_instr, imem_addr, fetch_count};

  function automatic logic [128:0] exp_vec();
    logic [63:0] h;
    h = q.size() > 0 ? q[0] : 64'h0;
    return {q.size() > 0, h, m_pc, m_fc};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 0;
    m_fc = 0;
  endtask

  task automatic step(input logic en, input logic rdy, input logic rv, input logic [31:0] tgt);
    logic pop, push;
    fetch_en = en;
    if_ready = rdy;
    redirect_valid = rv;
    redirect_target = tgt;
    @(posedge clk);
    if (rv) begin
      q.delete();
      m_pc = tgt & ~32'h3;
    end else begin
      pop = q.size() > 0 && rdy;
      push = en && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({m_pc, mem(m_pc)});
        m_pc += 4;
        m_fc += 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (obs !== 129'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", obs, 129'h0);
    end
    do_reset();
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      n_chk++;
      if (if_pc !== 32'(4 * i) || if_instr !== 32'(3 * (i + 1)) || fetch_count !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL stream[%0d] got pc=%h instr=%0d fc=%0d exp pc=%h instr=%0d fc=%0d",
                 i, if_pc, if_instr, fetch_count, 4 * i, 3 * (i + 1), i + 1);
      end
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream_model[%0d] got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_model[%0d] got %h exp %h", i, obs, exp_vec());
      end
    end
    n_chk++;
    if (imem_addr !== 32'h8 || if_instr !== 32'd3 || !if_valid) begin
      n_fail++;
      $display("FAIL stall_hold got addr=%h instr=%0d valid=%b exp addr=8 instr=3 valid=1",
               imem_addr, if_instr, if_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      n_chk++;
      if (if_instr !== 32'(3 * (i + 2))) begin
        n_fail++;
        $display("FAIL drain_order[%0d] got %0d exp %0d", i, if_instr, 3 * (i + 2));
      end
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain_model[%0d] got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] fc;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    fc = fetch_count;
    step(1, 1, 1, 32'h13);
    n_chk++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h10 || fetch_count !== fc) begin
      n_fail++;
      $display("FAIL redirect_flush got valid=%b addr=%h fc=%0d exp valid=0 addr=10 fc=%0d",
               if_valid, imem_addr, fetch_count, fc);
    end
    step(1, 1, 0, 0);
    n_chk++;
    if (if_pc !== 32'h10 || if_instr !== 32'd15) begin
      n_fail++;
      $display("FAIL redirect_target got pc=%h instr=%0d exp pc=10 instr=15", if_pc, if_instr);
    end
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL redirect_model got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_fetch_en();
    logic [31:0] frozen;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    frozen = imem_addr;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      n_chk++;
      if (obs !== exp_vec() || imem_addr !== frozen) begin
        n_fail++;
        $display("FAIL fetch_en_off[%0d] got %h exp %h", i, obs, exp_vec());
      end
    end
    n_chk++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drained_valid got %b exp 0", if_valid);
    end
    step(1, 1, 0, 0);
    n_chk++;
    if (if_pc !== frozen || if_instr !== mem(frozen)) begin
      n_fail++;
      $display("FAIL resume got pc=%h instr=%h exp pc=%h instr=%h", if_pc, if_instr, frozen, mem(frozen));
    end
  endtask

  task automatic test_wrap();
    step(1, 1, 1, 32'hFFFF_FFFE);
    step(1, 0, 0, 0);
    n_chk++;
    if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_addr got addr=%h pc=%h exp addr=0 pc=fffffffc", imem_addr, if_pc);
    end
    step(1, 1, 0, 0);
    n_chk++;
    if (if_pc !== 32'h0 || if_instr !== 32'd3) begin
      n_fail++;
      $display("FAIL wrap_next got pc=%h instr=%0d exp pc=0 instr=3", if_pc, if_instr);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #3;
    reset = 1;
    #1;
    n_chk++;
    if (obs !== 129'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", obs, 129'h0);
    end
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    step(1, 1, 0, 0);
    n_chk++;
    if (obs !== exp_vec() || if_instr !== 32'd3) begin
      n_fail++;
      $display("FAIL after_reset got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), $urandom);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got %h exp %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fetch_en();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
